// File: rtl/grng_pkg.sv
// rtl/grng_pkg.sv - shared GRNG constants and sample type
// Contents:
//   GRNG_SAMPLE_W   width of one GRNG output sample in bits
//   GRNG_RDR_DEPTH  default entry count of the consumer-side sample FIFO
//   grng_sample_t   signed two's-complement sample
package grng_pkg;

  localparam int GRNG_SAMPLE_W  = 32;
  localparam int GRNG_RDR_DEPTH = 4;

  typedef logic signed [GRNG_SAMPLE_W-1:0] grng_sample_t;

endpackage

// File: rtl/grng_fifo_ptr.sv
// rtl/grng_fifo_ptr.sv - wrapping FIFO pointer with increment enable
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, clears the pointer to 0
//   inc  advance the pointer by one this cycle
//   ptr  pointer value; PW bits, wraps modulo 2**PW
module grng_fifo_ptr #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  // PW is one bit wider than the memory index, so the natural binary
  // wrap gives modulo 2*DEPTH and keeps the lap bit for occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/grng_sample_reader.sv
// rtl/grng_sample_reader.sv - FIFO reader for the GRNG sample stream with drop accounting
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   in_valid/in_data sample from the core, no backpressure
//   out_valid/out_ready/out_data  first-word-fall-through handshake to the consumer
//   count            occupancy 0..DEPTH
//   overflow         sticky flag set when a sample is dropped
//   drop_cnt         saturating count of dropped samples
//   clr_ovf          pulse clearing overflow and drop_cnt
module grng_sample_reader
  import grng_pkg::*;
#(
  parameter int WIDTH = GRNG_SAMPLE_W,
  parameter int DEPTH = GRNG_RDR_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [WIDTH-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WIDTH-1:0]  out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  // Occupancy is the pointer distance; the extra lap bit distinguishes
  // full from empty, so count tracks push/pop without its own register.
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // A pop frees the slot the same cycle, so a full FIFO still accepts
  // an arriving sample when the consumer is draining.
  assign pop  = out_valid & out_ready & ~rst;
  assign push = in_valid & (~full | pop) & ~rst;
  assign drop = in_valid & full & ~pop & ~rst;

  grng_fifo_ptr #(.PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  grng_fifo_ptr #(.PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  // Storage is deliberately not reset; out_data gating hides stale words.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // A drop in the same cycle as clr_ovf restarts the tally at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

endmodule
